mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported word RAM between the core's instruction-fetch port and its load/store port. It sits between the CPU and `memory`. It accepts one request at a time and forwards it as a one-cycle `mem_ready` pulse. It routes the `mem_valid`/`mem_rdata` response back to the granted port. A bounded wait converts a missing response (out-of-range address) into a fault.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_rr.sv | 28 ++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the fetch / load-store memory arbiter.
//   state_t        : arbiter FSM states
//   port_t         : requester identity (fetch = PORT_I, load/store = PORT_D)
//   MEM_WSTRB_READ : byte-enable value that marks a read access
//   other_port()   : the opposite requester, used for tie breaking
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [3:0] MEM_WSTRB_READ = 4'b0000;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
// Combinational 2-way round-robin picker.
//   req   [1:0] in  : request vector, bit 0 = fetch, bit 1 = load/store
//   last        in  : port granted most recently (stored by the parent)
//   grant       out : winning port; only meaningful when req != 0
// A lone requester always wins; on a tie the port that did not win last time
// is chosen.
// -----------------------------------------------------------------------------
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    output port_t      grant
);

    always_comb begin
        grant = last;
        case (req)
            2'b01:   grant = PORT_I;
            2'b10:   grant = PORT_D;
            2'b11:   grant = other_port(last);
            default: grant = last;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-ported word RAM between the instruction-fetch port and
// the load/store port. One request is in flight at a time; it is issued to
// memory as a one-cycle mem_ready pulse and the response is routed back to
// the granted port as a one-cycle valid pulse. A response that never arrives
// (address outside the RAM) is turned into a fault after TIMEOUT cycles.
//
// Parameters
//   TIMEOUT   : WAIT cycles before faulting, legal 2..255
// Ports
//   clk, reset                      : clock, async active-high reset
//   i_ready / i_addr                : fetch request (held until i_valid)
//   i_valid / i_rdata / i_fault     : fetch response pulse, data, timeout flag
//   d_ready / d_addr / d_wdata /
//   d_wstrb                         : load/store request (wstrb 0 = load)
//   d_valid / d_rdata / d_fault     : load/store response pulse, data, flag
//   mem_ready / mem_addr /
//   mem_wdata / mem_wstrb           : request to memory (one-cycle pulse)
//   mem_valid / mem_rdata           : response from memory
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no transaction; requests are sampled and a winner is issued
// WAIT  | request issued, counting cycles until mem_valid or timeout
// DONE  | winner's valid pulse is high; requests are not sampled
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset,

    input  logic        i_ready,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_fault,

    input  logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_fault,

    output logic        mem_ready,
    input  logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned           CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    port_t              last_grant_q;
    port_t              pick;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         req;
    logic               timed_out;

    logic               mem_ready_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [3:0]         mem_wstrb_q;
    logic               i_valid_q, d_valid_q;
    logic               i_fault_q, d_fault_q;
    logic [31:0]        i_rdata_q, d_rdata_q;

    assign req       = {d_ready, i_ready};
    assign timed_out = (cnt_q == CNT_MAX);

    mem_arbiter_rr u_rr (
        .req   (req),
        .last  (last_grant_q),
        .grant (pick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = WAIT;
            WAIT:    if (mem_valid || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // While a transaction is in WAIT, last_grant_q is the port being served:
    // it is only written on grant, so it doubles as the response router.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_I;
            cnt_q        <= '0;
            mem_ready_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            i_fault_q    <= 1'b0;
            d_fault_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        last_grant_q <= pick;
                        mem_ready_q  <= 1'b1;
                        cnt_q        <= '0;
                        if (pick == PORT_D) begin
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_wstrb_q <= d_wstrb;
                        end else begin
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= MEM_WSTRB_READ;
                        end
                    end
                end
                WAIT: begin
                    mem_ready_q <= 1'b0;
                    // A response in the timeout cycle still counts as success.
                    if (mem_valid) begin
                        if (last_grant_q == PORT_D) begin
                            d_rdata_q <= mem_rdata;
                            d_valid_q <= 1'b1;
                            d_fault_q <= 1'b0;
                        end else begin
                            i_rdata_q <= mem_rdata;
                            i_valid_q <= 1'b1;
                            i_fault_q <= 1'b0;
                        end
                    end else if (timed_out) begin
                        if (last_grant_q == PORT_D) begin
                            d_rdata_q <= '0;
                            d_valid_q <= 1'b1;
                            d_fault_q <= 1'b1;
                        end else begin
                            i_rdata_q <= '0;
                            i_valid_q <= 1'b1;
                            i_fault_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    i_valid_q <= 1'b0;
                    d_valid_q <= 1'b0;
                    i_fault_q <= 1'b0;
                    d_fault_q <= 1'b0;
                end
                default: begin
                    mem_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_valid   = i_valid_q;
    assign i_rdata   = i_rdata_q;
    assign i_fault   = i_fault_q;
    assign d_valid   = d_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_fault   = d_fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TIMEOUT   = 16;
    localparam int RAM_WORDS = 64;
    localparam int TO_LAT    = TIMEOUT + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_ready, d_ready;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        i_valid, d_valid, i_fault, d_fault;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_ready   (i_ready),
        .i_addr    (i_addr),
        .i_valid   (i_valid),
        .i_rdata   (i_rdata),
        .i_fault   (i_fault),
        .d_ready   (d_ready),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .d_fault   (d_fault),
        .mem_ready (mem_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    // Memory model: one-cycle responder, silent for out-of-range addresses.
    logic [31:0] ram [RAM_WORDS];
    logic        mv_q = 1'b0;
    logic [31:0] mrd_q = '0;
    logic        force_valid;
    logic        mem_init;

    assign mem_valid = mv_q | force_valid;
    assign mem_rdata = mrd_q;

    always @(posedge clk) begin
        mv_q <= 1'b0;
        if (mem_init) begin
            for (int w = 0; w < RAM_WORDS; w++) ram[w] <= '0;
            ram[4] <= 32'hDEADBEEF;
            ram[8] <= 32'hAABBCCDD;
        end else if (mem_ready && !mem_valid && (mem_addr < 32'(4 * RAM_WORDS))) begin
            mrd_q <= ram[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mv_q <= 1'b1;
        end
    end

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Starts in an IDLE-state cycle at a negedge; returns at the negedge of
    // the following IDLE cycle.
    task automatic do_txn(input string nm, input bit is_d, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_rdata, input bit exp_fault,
                          input int exp_lat);
        int  n;
        int  rdy_cnt;
        int  other_cnt;
        bit  seen;
        if (is_d) begin
            d_ready = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        end else begin
            i_ready = 1'b1; i_addr = addr;
        end
        n = 0; rdy_cnt = 0; other_cnt = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (mem_ready) rdy_cnt++;
            if (n == 1) begin
                chk({nm, " ready_c1"}, 32'(mem_ready), 32'd1);
                chk({nm, " mem_addr"}, mem_addr, addr);
                chk({nm, " mem_wdata"}, mem_wdata, is_d ? wdata : 32'h0);
                chk({nm, " mem_wstrb"}, 32'(mem_wstrb), is_d ? 32'(wstrb) : 32'h0);
            end
            if (is_d ? i_valid : d_valid) other_cnt++;
            if (is_d ? d_valid : i_valid) begin
                seen = 1'b1;
                chk({nm, " latency"}, 32'(n), 32'(exp_lat));
                chk({nm, " rdata"}, is_d ? d_rdata : i_rdata, exp_rdata);
                chk({nm, " fault"}, 32'(is_d ? d_fault : i_fault), 32'(exp_fault));
                if (is_d) d_ready = 1'b0; else i_ready = 1'b0;
            end
        end
        if (!seen) begin
            chk({nm, " no_valid_timeout"}, 32'd0, 32'd1);
            i_ready = 1'b0; d_ready = 1'b0;
        end
        chk({nm, " ready_cycles"}, 32'(rdy_cnt), 32'd1);
        chk({nm, " other_quiet"}, 32'(other_cnt), 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        bit          exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          vcyc [4];
        int          vport[4];
        logic [31:0] vdat [4];
        logic [31:0] gaddr[4];
        int          nv, ng, cnt;

        vecs[0]  = '{0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 0, 3};
        vecs[1]  = '{1, 32'h20,  32'h11223344, 4'b0011, 32'hAABBCCDD, 0, 3};
        vecs[2]  = '{1, 32'h20,  32'h0,        4'b0000, 32'hAABB3344, 0, 3};
        vecs[3]  = '{0, 32'h20,  32'h0,        4'b0000, 32'hAABB3344, 0, 3};
        vecs[4]  = '{1, 32'h30,  32'hFFFFFFFF, 4'b1000, 32'h00000000, 0, 3};
        vecs[5]  = '{1, 32'h30,  32'h0,        4'b0000, 32'hFF000000, 0, 3};
        vecs[6]  = '{1, 32'h100, 32'h0,        4'b0000, 32'h00000000, 1, TO_LAT};
        vecs[7]  = '{0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 0, 3};
        vecs[8]  = '{0, 32'h104, 32'h0,        4'b0000, 32'h00000000, 1, TO_LAT};
        vecs[9]  = '{1, 32'h14,  32'h12345678, 4'b1111, 32'h00000000, 0, 3};
        vecs[10] = '{0, 32'h14,  32'h0,        4'b0000, 32'h12345678, 0, 3};

        reset = 1'b1; mem_init = 1'b1; force_valid = 1'b0;
        i_ready = 1'b0; i_addr = '0;
        d_ready = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;

        chk("rst mem_ready", 32'(mem_ready), 32'd0);
        chk("rst valids", {30'd0, i_valid, d_valid}, 32'd0);
        chk("rst faults", {30'd0, i_fault, d_fault}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);

        // Tie from reset: both held, grant order D, I, D, I.
        reset = 1'b0;
        i_ready = 1'b1; i_addr = 32'h10;
        d_ready = 1'b1; d_addr = 32'h20; d_wdata = 32'h0; d_wstrb = 4'b0000;
        nv = 0; ng = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (mem_ready && ng < 4) begin gaddr[ng] = mem_addr; ng++; end
            if ((d_valid || i_valid) && nv < 4) begin
                vcyc[nv]  = n;
                vport[nv] = d_valid ? 1 : 0;
                vdat[nv]  = d_valid ? d_rdata : i_rdata;
                nv++;
            end
            if (n == 15) begin i_ready = 1'b0; d_ready = 1'b0; end
        end
        chk("tie grant_count", 32'(ng), 32'd4);
        chk("tie valid_count", 32'(nv), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie cycle%0d", k), 32'(vcyc[k]), 32'(3 + 4 * k));
            chk($sformatf("tie port%0d", k), 32'(vport[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("tie addr%0d", k), gaddr[k], (k % 2 == 0) ? 32'h20 : 32'h10);
            chk($sformatf("tie rdata%0d", k), vdat[k],
                (k % 2 == 0) ? 32'hAABBCCDD : 32'hDEADBEEF);
        end

        for (int v = 0; v < 11; v++)
            do_txn($sformatf("vec%0d", v), vecs[v].is_d, vecs[v].addr, vecs[v].wdata,
                   vecs[v].wstrb, vecs[v].exp_rdata, vecs[v].exp_fault, vecs[v].exp_lat);

        // Reset in WAIT after memory has sampled a store.
        d_ready = 1'b1; d_addr = 32'h18; d_wdata = 32'hCAFEF00D; d_wstrb = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; d_ready = 1'b0;
        #1;
        chk("rstw mem_ready", 32'(mem_ready), 32'd0);
        chk("rstw mem_addr", mem_addr, 32'd0);
        chk("rstw mem_wdata", mem_wdata, 32'd0);
        chk("rstw mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rstw d_rdata", d_rdata, 32'd0);
        chk("rstw i_rdata", i_rdata, 32'd0);
        chk("rstw valids", {30'd0, i_valid, d_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (i_valid || d_valid) cnt++;
        end
        chk("rstw no_valid_after", 32'(cnt), 32'd0);
        chk("rstw ram_written", ram[6], 32'hCAFEF00D);
        do_txn("rstw reload", 1'b1, 32'h18, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 3);

        // Stray mem_valid in IDLE.
        force_valid = 1'b1;
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (i_valid || d_valid) cnt++;
        end
        force_valid = 1'b0;
        chk("stub idle no_valid", 32'(cnt), 32'd0);
        do_txn("stub idle after", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 3);

        // Stray mem_valid starting in DONE and continuing into IDLE.
        i_ready = 1'b1; i_addr = 32'h20;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("stub done i_valid", 32'(i_valid), 32'd1);
        chk("stub done i_rdata", i_rdata, 32'hAABB3344);
        i_ready = 1'b0; force_valid = 1'b1;
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (i_valid || d_valid) cnt++;
        end
        force_valid = 1'b0;
        chk("stub done no_valid", 32'(cnt), 32'd0);
        do_txn("stub done after", 1'b1, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
